// File: rtl/rr_crossbar_switch.sv
// INPUTS x OUTPUTS flit crossbar: each output arbitrates round-robin among requesting inputs,
// then locks to the winner from the grant until its tail flit transfers (wormhole switching).
//
// state     | meaning
// ST_IDLE   | output free; picks the first requester at or after ptr_q, grant takes effect next cycle
// ST_LOCKED | output owned by owner_q; flits pass through combinationally until the tail transfers
module rr_crossbar_switch #(
  parameter int INPUTS     = 4,
  parameter int OUTPUTS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INPUTS*DATA_WIDTH-1:0]  data_in,
  input  logic [INPUTS*DEST_WIDTH-1:0]  dest_in,
  input  logic [INPUTS-1:0]             last_in,
  input  logic [INPUTS-1:0]             valid_in,
  output logic [INPUTS-1:0]             ready_in,
  output logic [OUTPUTS*DATA_WIDTH-1:0] data_out,
  output logic [OUTPUTS-1:0]            last_out,
  output logic [OUTPUTS-1:0]            valid_out,
  input  logic [OUTPUTS-1:0]            ready_out,
  output logic [OUTPUTS-1:0]            out_busy,
  output logic [INPUTS-1:0]             err_dest
);

  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam logic [DEST_WIDTH:0] OUT_LIM = (DEST_WIDTH + 1)'(OUTPUTS);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t            state_q [OUTPUTS];
  state_t            state_d [OUTPUTS];
  logic [IW-1:0]     owner_q [OUTPUTS];
  logic [IW-1:0]     owner_d [OUTPUTS];
  logic [IW-1:0]     ptr_q   [OUTPUTS];
  logic [IW-1:0]     ptr_d   [OUTPUTS];
  logic [INPUTS-1:0] err_q;
  logic [INPUTS-1:0] err_d;

  logic [DATA_WIDTH-1:0] data_arr [INPUTS];
  logic [DEST_WIDTH-1:0] dest_arr [INPUTS];
  logic [INPUTS-1:0]     dest_ok;
  logic [INPUTS-1:0]     in_locked;
  logic [INPUTS-1:0]     req     [OUTPUTS];
  logic [IW:0]           pick    [OUTPUTS];
  logic [OUTPUTS-1:0]    tail_xfer;

  // Round-robin search: lowest offset k from p wins, so scan offsets downward and let the last hit stick.
  function automatic logic [IW:0] rr_pick(input logic [INPUTS-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % INPUTS;
      if (r[IW'(idx)]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_in
    assign data_arr[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign dest_arr[gi] = dest_in[gi*DEST_WIDTH +: DEST_WIDTH];
    assign dest_ok[gi]  = ({1'b0, dest_arr[gi]} < OUT_LIM);
  end

  for (genvar go = 0; go < OUTPUTS; go++) begin : g_out
    assign out_busy[go] = (state_q[go] == ST_LOCKED);
  end

  assign err_dest = err_q;

  always_comb begin
    in_locked = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      if (state_q[o] == ST_LOCKED) in_locked[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < INPUTS; i++) begin
        req[o][i] = valid_in[i] && dest_ok[i] && !in_locked[i] &&
                    (dest_arr[i] == DEST_WIDTH'(o));
      end
      pick[o] = rr_pick(req[o], ptr_q[o]);
    end
  end

  always_comb begin
    data_out  = '0;
    last_out  = '0;
    valid_out = '0;
    ready_in  = '0;
    tail_xfer = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        data_out[o*DATA_WIDTH +: DATA_WIDTH] = data_arr[owner_q[o]];
        last_out[o]          = last_in[owner_q[o]];
        valid_out[o]         = valid_in[owner_q[o]];
        ready_in[owner_q[o]] = ready_out[o];
        tail_xfer[o]         = valid_in[owner_q[o]] && ready_out[o] && last_in[owner_q[o]];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == ST_IDLE) begin
        if (pick[o][IW]) begin
          state_d[o] = ST_LOCKED;
          owner_d[o] = pick[o][IW-1:0];
        end
      end else if (tail_xfer[o]) begin
        state_d[o] = ST_IDLE;
        ptr_d[o]   = (owner_q[o] == IW'(INPUTS - 1)) ? '0 : owner_q[o] + 1'b1;
      end
    end
  end

  always_comb begin
    err_d = '0;
    for (int i = 0; i < INPUTS; i++) begin
      err_d[i] = valid_in[i] && !dest_ok[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      err_q <= '0;
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_rr_crossbar_switch.sv
// Bench for rr_crossbar_switch (4 inputs, 3 outputs so dest=3 is out of range): directed
// scenarios with literal expectations, then random traffic against a per-cycle behavioural model.
module tb_rr_crossbar_switch;

  localparam int INPUTS  = 4;
  localparam int OUTPUTS = 3;
  localparam int DW      = 32;
  localparam int DSW     = 2;
  localparam int IW      = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [INPUTS*DW-1:0]     data_in;
  logic [INPUTS*DSW-1:0]    dest_in;
  logic [INPUTS-1:0]        last_in;
  logic [INPUTS-1:0]        valid_in;
  logic [INPUTS-1:0]        ready_in;
  logic [OUTPUTS*DW-1:0]    data_out;
  logic [OUTPUTS-1:0]       last_out;
  logic [OUTPUTS-1:0]       valid_out;
  logic [OUTPUTS-1:0]       ready_out;
  logic [OUTPUTS-1:0]       out_busy;
  logic [INPUTS-1:0]        err_dest;

  logic [DW-1:0]  din  [INPUTS];
  logic [DSW-1:0] dst  [INPUTS];
  logic [DW-1:0]  dout [OUTPUTS];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_pack
    assign data_in[gi*DW +: DW]   = din[gi];
    assign dest_in[gi*DSW +: DSW] = dst[gi];
  end
  for (genvar go = 0; go < OUTPUTS; go++) begin : g_unpack
    assign dout[go] = data_out[go*DW +: DW];
  end

  rr_crossbar_switch #(
    .INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .DATA_WIDTH(DW), .DEST_WIDTH(DSW)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .dest_in(dest_in), .last_in(last_in), .valid_in(valid_in),
    .ready_in(ready_in),
    .data_out(data_out), .last_out(last_out), .valid_out(valid_out), .ready_out(ready_out),
    .out_busy(out_busy), .err_dest(err_dest)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner per output (-1 = free), round-robin pointer, registered error flags.
  int               m_own [OUTPUTS];
  int               m_ptr [OUTPUTS];
  logic [INPUTS-1:0] m_err;
  bit               m_lk  [INPUTS];

  always @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        m_own[o] = -1;
        m_ptr[o] = 0;
      end
      m_err  = '0;
      chk_en = 1'b1;
    end else begin
      for (int i = 0; i < INPUTS; i++) m_lk[i] = 1'b0;
      for (int o = 0; o < OUTPUTS; o++) if (m_own[o] >= 0) m_lk[IW'(m_own[o])] = 1'b1;
      for (int i = 0; i < INPUTS; i++)
        m_err[IW'(i)] = valid_in[IW'(i)] && (int'(dst[IW'(i)]) >= OUTPUTS);
      for (int o = 0; o < OUTPUTS; o++) begin
        if (m_own[o] >= 0) begin
          int k;
          k = m_own[o];
          if (valid_in[IW'(k)] && ready_out[IW'(o)] && last_in[IW'(k)]) begin
            m_own[o] = -1;
            m_ptr[o] = (k + 1) % INPUTS;
          end
        end else begin
          for (int s = 0; s < INPUTS; s++) begin
            int c;
            c = (m_ptr[o] + s) % INPUTS;
            if (m_own[o] < 0 && valid_in[IW'(c)] && !m_lk[IW'(c)] && int'(dst[IW'(c)]) == o)
              m_own[o] = c;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [OUTPUTS-1:0] e_val, e_last, e_busy;
      logic [INPUTS-1:0]  e_rdy;
      logic [DW-1:0]      e_dat;
      e_val = '0; e_last = '0; e_busy = '0; e_rdy = '0;
      for (int o = 0; o < OUTPUTS; o++) begin
        e_dat = '0;
        if (m_own[o] >= 0) begin
          e_dat              = din[IW'(m_own[o])];
          e_val[IW'(o)]      = valid_in[IW'(m_own[o])];
          e_last[IW'(o)]     = last_in[IW'(m_own[o])];
          e_busy[IW'(o)]     = 1'b1;
          e_rdy[IW'(m_own[o])] = ready_out[IW'(o)];
        end
        check("model_data_out", dout[IW'(o)], e_dat);
      end
      check("model_valid_out", valid_out, e_val);
      check("model_last_out", last_out, e_last);
      check("model_ready_in", ready_in, e_rdy);
      check("model_out_busy", out_busy, e_busy);
      check("model_err_dest", err_dest, m_err);
    end
  end

  logic [INPUTS-1:0] acc;
  logic [DW-1:0]     ed [8];
  bit                ev [8];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Single-flit packets to output o: literal per-cycle valid/data, drop each input once accepted.
  task automatic serve(input int o, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("dir_rr_valid", valid_out[IW'(o)], ev[3'(c)]);
      if (ev[3'(c)]) check("dir_rr_data", dout[IW'(o)], ed[3'(c)]);
      acc = valid_in & ready_in;
      nxt();
      valid_in = valid_in & ~acc;
    end
  endtask

  bit g_act [INPUTS];
  int g_left[INPUTS];
  int g_tmo [INPUTS];
  int seq = 0;

  initial begin
    rst = 1'b1; valid_in = '0; last_in = '0; ready_out = '1;
    for (int i = 0; i < INPUTS; i++) begin din[i] = '0; dst[i] = '0; end
    nxt();
    @(negedge clk);
    check("rst_out_busy", out_busy, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_err_dest", err_dest, 0);
    nxt();
    rst = 1'b0;
    repeat (2) nxt();
    @(negedge clk);
    check("idle_valid_out", valid_out, 0);
    check("idle_data_out", data_out, 0);
    nxt();

    // 3-flit packet In0 -> out2
    valid_in[0] = 1'b1; dst[0] = 2'd2; din[0] = 32'hA000_0001; last_in[0] = 1'b0;
    @(negedge clk);
    check("grant_cycle_busy", out_busy[2], 0);
    check("grant_cycle_valid", valid_out, 0);
    nxt();
    @(negedge clk);
    check("pkt_busy_c1", out_busy[2], 1);
    check("pkt_a1", dout[2], 32'hA000_0001);
    check("pkt_ready_c1", ready_in[0], 1);
    nxt();
    din[0] = 32'hA000_0002;
    @(negedge clk);
    check("pkt_a2", dout[2], 32'hA000_0002);
    nxt();
    din[0] = 32'hA000_0003; last_in[0] = 1'b1;
    @(negedge clk);
    check("pkt_a3", dout[2], 32'hA000_0003);
    check("pkt_last", last_out[2], 1);
    nxt();
    valid_in[0] = 1'b0; last_in[0] = 1'b0;
    @(negedge clk);
    check("pkt_release", out_busy[2], 0);
    nxt();

    // Round-robin: In0, In1, In3 to out1
    for (int i = 0; i < INPUTS; i++) begin dst[i] = 2'd1; din[i] = 32'hD000_0000 + 32'(i); end
    valid_in = 4'b1011; last_in = 4'b1111;
    ev[0] = 0; ev[1] = 1; ev[2] = 0; ev[3] = 1; ev[4] = 0; ev[5] = 1;
    ed[1] = 32'hD000_0000; ed[3] = 32'hD000_0001; ed[5] = 32'hD000_0003;
    serve(1, 6);
    check("rr_all_served", valid_in, 0);
    // pointer wrapped back to 0: In0 beats In3
    din[0] = 32'hE000_0000; din[3] = 32'hE000_0003;
    valid_in = 4'b1001;
    ev[0] = 0; ev[1] = 1; ev[2] = 0; ev[3] = 1;
    ed[1] = 32'hE000_0000; ed[3] = 32'hE000_0003;
    serve(1, 4);

    // Parallel grants: In0 -> out2, In2 -> out0
    dst[0] = 2'd2; din[0] = 32'hF000_0000; dst[2] = 2'd0; din[2] = 32'hF000_0002;
    valid_in = 4'b0101; last_in = 4'b0101;
    @(negedge clk);
    check("par_grant_busy", out_busy, 0);
    nxt();
    @(negedge clk);
    check("par_busy", out_busy, 3'b101);
    check("par_valid", valid_out, 3'b101);
    check("par_data0", dout[0], 32'hF000_0002);
    check("par_data2", dout[2], 32'hF000_0000);
    acc = valid_in & ready_in;
    nxt();
    valid_in = valid_in & ~acc; last_in = '0;
    @(negedge clk);
    check("par_release", out_busy, 0);
    nxt();

    // Backpressure: In1 -> out2, ready_out[2] low 4 cycles after lock
    dst[1] = 2'd2; din[1] = 32'hB000_0001; valid_in[1] = 1'b1;
    nxt();
    ready_out[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_valid", valid_out[2], 1);
      check("bp_ready", ready_in[1], 0);
      check("bp_hold", dout[2], 32'hB000_0001);
      nxt();
    end
    ready_out[2] = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      din[1] = 32'hB000_0000 + 32'(j); last_in[1] = (j == 3);
      @(negedge clk);
      check("bp_resume", dout[2], 32'hB000_0000 + 32'(j));
      check("bp_ready_on", ready_in[1], 1);
      nxt();
    end
    valid_in[1] = 1'b0; last_in[1] = 1'b0;
    @(negedge clk);
    check("bp_release", out_busy[2], 0);
    nxt();

    // Out-of-range destination
    dst[2] = 2'd3; din[2] = 32'hEE00_0002; valid_in[2] = 1'b1;
    nxt();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bad_err", err_dest, 4'b0100);
      check("bad_ready", ready_in[2], 0);
      check("bad_busy", out_busy, 0);
      nxt();
    end
    valid_in[2] = 1'b0;
    nxt();
    @(negedge clk);
    check("bad_err_clear", err_dest, 0);

    // Reset mid-packet on In0 -> out0
    nxt();
    dst[0] = 2'd0; din[0] = 32'hC000_0001; valid_in[0] = 1'b1;
    nxt();
    @(negedge clk);
    check("mid_busy", out_busy[0], 1);
    nxt();
    din[0] = 32'hC000_0002; rst = 1'b1;
    nxt();
    rst = 1'b0; valid_in[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_clear", out_busy, 0);
    check("mid_rst_valid", valid_out, 0);
    nxt();

    // Random traffic
    for (int i = 0; i < INPUTS; i++) g_act[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = valid_in & ready_in;
      nxt();
      rst = (cyc == 1500);
      for (int i = 0; i < INPUTS; i++) begin
        if (acc[IW'(i)]) begin
          if (last_in[IW'(i)]) g_act[i] = 1'b0;
          else begin
            g_left[i]--;
            din[i] = {8'(i), 24'(seq)}; seq++;
          end
        end
        if (rst) g_act[i] = 1'b0;
        if (!rst && !g_act[i] && ($urandom % 3 == 0)) begin
          g_act[i]  = 1'b1;
          g_left[i] = 1 + int'($urandom_range(0, 3));
          g_tmo[i]  = 1 + int'($urandom_range(0, 4));
          dst[i]    = 2'($urandom_range(0, 3));
          din[i]    = {8'(i), 24'(seq)}; seq++;
        end
        if (g_act[i] && int'(dst[i]) >= OUTPUTS) begin
          g_tmo[i]--;
          if (g_tmo[i] <= 0) g_act[i] = 1'b0;
        end
        valid_in[IW'(i)] = g_act[i] && ($urandom % 5 != 0);
        last_in[IW'(i)]  = g_act[i] && (g_left[i] == 1);
      end
      ready_out = 3'($urandom);
    end
    rst = 1'b0; valid_in = '0;
    repeat (3) nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
